// File: rtl/part_join_pkg.sv
// part_join_pkg: shared definitions for the part_join_n combiner.
//   mode_e  : combine-mode encoding driven on i_mode.
//   clog2() : pointer-width helper for the per-channel FIFOs.
package part_join_pkg;

  typedef enum logic [1:0] {
    MODE_SUM  = 2'd0,
    MODE_MAC  = 2'd1,
    MODE_MAX  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/part_join_n_if.sv
// part_join_n_if: write bus and output valid/ready port of part_join_n.
//   i_wen/i_data   : per-channel write strobes and packed words (channel k at [k*W +: W])
//   o_full/o_ovf   : per-channel FIFO full and sticky overflow flags
//   o_valid/i_ready/o_data : combined-result handshake
// master = traffic source/sink around the block, slave = the block itself.
interface part_join_n_if #(
  parameter int unsigned NCH = 3,
  parameter int unsigned W   = 8,
  parameter int unsigned OW  = 8
);
  logic [NCH-1:0]   i_wen;
  logic [NCH*W-1:0] i_data;
  logic [NCH-1:0]   o_full;
  logic [NCH-1:0]   o_ovf;
  logic             o_valid;
  logic             i_ready;
  logic [OW-1:0]    o_data;

  modport master (
    output i_wen, i_data, i_ready,
    input  o_full, o_ovf, o_valid, o_data
  );

  modport slave (
    input  i_wen, i_data, i_ready,
    output o_full, o_ovf, o_valid, o_data
  );
endinterface

// File: rtl/part_sync_fifo.sv
// part_sync_fifo: single-clock FIFO, DEPTH words of W bits (DEPTH power of 2).
//   i_clk, i_rst  : clock, synchronous active-high reset (empties the FIFO)
//   i_push/i_din  : store i_din when not full (push while full is dropped)
//   i_pop         : discard the head word when not empty
//   o_head        : current head word (valid while !o_empty)
//   o_empty/o_full/o_count : occupancy, judged on the pre-edge count
module part_sync_fifo
  import part_join_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic [W-1:0]              i_din,
  output logic [W-1:0]              o_head,
  output logic                      o_empty,
  output logic                      o_full,
  output logic [clog2(DEPTH):0]     o_count
);
  localparam int unsigned AW = clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst) r_mem[r_wptr] <= i_din;
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
    end
  end
endmodule

// File: rtl/part_join_n.sv
// part_join_n: N-channel join-and-combine block.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_mode       : 0 SUM, 1 MAC (ch0 + ch1*ch2), 2 MAX, 3 as SUM
//   i_clr_ovf    : clears all sticky overflow flags (a new overflow wins)
//   o_joins      : wrapping count of joins performed
//   io_bus       : write bus, full/overflow flags and valid/ready result port
// One word is popped from every FIFO together when all are non-empty and the
// output register is free or being drained this cycle.
module part_join_n
  import part_join_pkg::*;
#(
  parameter int unsigned NCH   = 3,
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned OW    = 8,
  parameter int unsigned CNTW  = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [1:0]      i_mode,
  input  logic            i_clr_ovf,
  output logic [CNTW-1:0] o_joins,
  part_join_n_if.slave    io_bus
);
  localparam int unsigned AW  = clog2(DEPTH);
  localparam int unsigned XW0 = 2*W + 4;
  localparam int unsigned XW  = (XW0 > OW) ? XW0 : OW;

  logic [W-1:0]    w_head  [NCH];
  logic [AW:0]     w_count [NCH];
  logic [NCH-1:0]  w_empty;
  logic [NCH-1:0]  w_full;
  logic [NCH-1:0]  w_ovf_set;
  logic            w_fire;
  logic [XW-1:0]   w_sum;
  logic [XW-1:0]   w_max;
  logic [XW-1:0]   w_mac;
  logic [OW-1:0]   w_comb;

  logic            r_valid;
  logic [OW-1:0]   r_data;
  logic [CNTW-1:0] r_joins;
  logic [NCH-1:0]  r_ovf;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    part_sync_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (io_bus.i_wen[k]),
      .i_pop   (w_fire),
      .i_din   (io_bus.i_data[k*W +: W]),
      .o_head  (w_head[k]),
      .o_empty (w_empty[k]),
      .o_full  (w_full[k]),
      .o_count (w_count[k])
    );
    // Overflow uses the pre-edge count, so a same-cycle pop does not rescue the word.
    assign w_ovf_set[k] = io_bus.i_wen[k] && (w_count[k] == (AW+1)'(DEPTH));
  end

  assign w_fire = (w_empty == '0) && (!r_valid || io_bus.i_ready);

  always_comb begin
    w_sum = '0;
    w_max = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      w_sum = w_sum + XW'(w_head[k]);
      if (XW'(w_head[k]) > w_max) w_max = XW'(w_head[k]);
    end
  end

  if (NCH >= 3) begin : g_mac
    assign w_mac = XW'(w_head[0]) + XW'(w_head[1]) * XW'(w_head[2]);
  end else begin : g_no_mac
    assign w_mac = w_sum;
  end

  always_comb begin
    w_comb = '0;
    case (mode_e'(i_mode))
      MODE_MAC: w_comb = w_mac[OW-1:0];
      MODE_MAX: w_comb = w_max[OW-1:0];
      default:  w_comb = w_sum[OW-1:0];
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_joins <= '0;
      r_ovf   <= '0;
    end else begin
      r_ovf <= (i_clr_ovf ? '0 : r_ovf) | w_ovf_set;
      if (w_fire) begin
        r_valid <= 1'b1;
        r_data  <= w_comb;
        r_joins <= r_joins + CNTW'(1);
      end else if (io_bus.i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign io_bus.o_full  = w_full;
  assign io_bus.o_ovf   = r_ovf;
  assign io_bus.o_valid = r_valid;
  assign io_bus.o_data  = r_data;
  assign o_joins        = r_joins;
endmodule

// File: tb/tb_part_join_n.sv
// Bench for part_join_n: directed scenarios plus random traffic, checked by a
// queue-based reference model and a scoreboard monitor on the output port.
module tb_part_join_n;
  import part_join_pkg::*;

  localparam int unsigned NCH = 3, W = 8, DEPTH = 4, OW = 8, CNTW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            clr = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic [CNTW-1:0] joins;

  part_join_n_if #(.NCH(NCH), .W(W), .OW(OW)) bus ();

  part_join_n #(.NCH(NCH), .W(W), .DEPTH(DEPTH), .OW(OW), .CNTW(CNTW)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_mode    (mode),
    .i_clr_ovf (clr),
    .o_joins   (joins),
    .io_bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct { int data; int idx; } exp_t;

  int           checks = 0;
  int           errors = 0;
  exp_t         sb[$];
  int           q[NCH][$];
  bit           m_valid = 0;
  bit [NCH-1:0] m_ovf = '0;
  int           m_joins = 0;
  bit           mon_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int combine(input int h[NCH], input logic [1:0] md);
    int r;
    r = 0;
    if (md == 2'd1) begin
      r = h[0] + h[1] * h[2];
    end else if (md == 2'd2) begin
      for (int k = 0; k < NCH; k++) if (h[k] > r) r = h[k];
    end else begin
      for (int k = 0; k < NCH; k++) r += h[k];
    end
    return r % (1 << OW);
  endfunction

  // Reference model: evaluated at each rising edge with the inputs present at that edge.
  function automatic void model();
    bit           all_ne;
    bit [NCH-1:0] was_full;
    int           h[NCH];
    exp_t         e;
    if (rst) begin
      for (int k = 0; k < NCH; k++) q[k].delete();
      sb.delete();
      m_valid = 0;
      m_ovf   = '0;
      m_joins = 0;
      return;
    end
    all_ne = 1;
    for (int k = 0; k < NCH; k++) begin
      was_full[k] = (q[k].size() == DEPTH);
      if (q[k].size() == 0) all_ne = 0;
    end
    if (all_ne && (!m_valid || bus.i_ready)) begin
      for (int k = 0; k < NCH; k++) h[k] = q[k].pop_front();
      m_joins = (m_joins + 1) % (1 << CNTW);
      e.data = combine(h, mode);
      e.idx  = m_joins;
      sb.push_back(e);
      m_valid = 1;
    end else if (bus.i_ready) begin
      m_valid = 0;
    end
    if (clr) m_ovf = '0;
    for (int k = 0; k < NCH; k++)
      if (bus.i_wen[k]) begin
        if (was_full[k]) m_ovf[k] = 1'b1;
        else q[k].push_back(int'(bus.i_data[k*W +: W]));
      end
  endfunction

  task automatic cyc();
    @(posedge clk);
    model();
    #1;
  endtask

  task automatic put(input logic [NCH-1:0] wen, input int a, input int b, input int c);
    bus.i_wen = wen;
    bus.i_data[0*W +: W] = W'(a);
    bus.i_data[1*W +: W] = W'(b);
    bus.i_data[2*W +: W] = W'(c);
  endtask

  // Scoreboard monitor: inspects the port mid-cycle, pops on each accepted word.
  always @(negedge clk) begin
    exp_t         e;
    bit [NCH-1:0] fv;
    if (mon_en) begin
      for (int k = 0; k < NCH; k++) fv[k] = (q[k].size() == DEPTH);
      chk("o_valid", 64'(bus.o_valid), 64'(m_valid));
      chk("o_full",  64'(bus.o_full),  64'(fv));
      chk("o_ovf",   64'(bus.o_ovf),   64'(m_ovf));
      chk("o_joins", 64'(joins),       64'(m_joins));
      if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow actual=word_presented expected=none at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("o_data", 64'(bus.o_data), 64'(e.data));
          chk("join_idx", 64'(joins), 64'(e.idx));
        end
      end
    end
  end

  initial begin
    put('0, 0, 0, 0);
    bus.i_ready = 1'b1;

    // Reset
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    mon_en = 1;
    chk("rst_valid", 64'(bus.o_valid), 0);
    chk("rst_data",  64'(bus.o_data),  0);
    chk("rst_joins", 64'(joins),       0);
    chk("rst_full",  64'(bus.o_full),  0);
    chk("rst_ovf",   64'(bus.o_ovf),   0);

    // MAC 5 + 3*4 with one-edge latency
    mode = 2'd1;
    put(3'b111, 5, 3, 4);
    cyc();
    put('0, 0, 0, 0);
    chk("mac_not_yet", 64'(bus.o_valid), 0);
    cyc();
    chk("mac_valid", 64'(bus.o_valid), 1);
    chk("mac_data",  64'(bus.o_data),  17);
    chk("mac_joins", 64'(joins),       1);
    cyc();
    chk("mac_pulse", 64'(bus.o_valid), 0);

    // SUM wrap and MAX
    mode = 2'd0;
    put(3'b111, 200, 100, 10);
    cyc();
    put('0, 0, 0, 0);
    cyc();
    chk("sum_data", 64'(bus.o_data), 54);
    mode = 2'd2;
    put(3'b111, 7, 250, 9);
    cyc();
    put('0, 0, 0, 0);
    cyc();
    chk("max_data", 64'(bus.o_data), 250);
    cyc();

    // Backpressure with three queued joins
    mode = 2'd0;
    bus.i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(3'b111, i + 1, 2, 3);
      cyc();
    end
    put('0, 0, 0, 0);
    repeat (3) cyc();
    chk("bp_valid", 64'(bus.o_valid), 1);
    chk("bp_hold",  64'(bus.o_data),  6);
    bus.i_ready = 1'b1;
    cyc();
    chk("bp_r1", 64'(bus.o_data), 7);
    cyc();
    chk("bp_r2", 64'(bus.o_data), 8);
    cyc();
    chk("bp_drained", 64'(bus.o_valid), 0);

    // Overflow on channel 0
    for (int i = 0; i < 5; i++) begin
      put(3'b001, 10 + i, 0, 0);
      cyc();
      chk("ovf_full0", 64'(bus.o_full[0]), (i >= 3) ? 64'd1 : 64'd0);
      chk("ovf_flag0", 64'(bus.o_ovf[0]),  (i >= 4) ? 64'd1 : 64'd0);
    end
    put('0, 0, 0, 0);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("ovf_clr", 64'(bus.o_ovf[0]), 0);
    for (int i = 0; i < 4; i++) begin
      put(3'b110, 0, i, 0);
      cyc();
    end
    put('0, 0, 0, 0);
    repeat (3) cyc();

    // Partial data: channel 2 starved
    put(3'b011, 1, 2, 0);
    cyc();
    put(3'b001, 50, 0, 0);
    cyc();
    put('0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("partial_idle", 64'(bus.o_valid), 0);
    end
    put(3'b100, 0, 0, 3);
    cyc();
    put('0, 0, 0, 0);
    cyc();
    chk("partial_valid", 64'(bus.o_valid), 1);
    chk("partial_data",  64'(bus.o_data),  6);
    cyc();
    chk("partial_single", 64'(bus.o_valid), 0);

    // Mid-stream reset with words buffered and output pending
    bus.i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(3'b111, 20 + i, 1, 1);
      cyc();
    end
    put('0, 0, 0, 0);
    cyc();
    chk("pre_rst_valid", 64'(bus.o_valid), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(bus.o_valid), 0);
    chk("mid_rst_joins", 64'(joins),       0);
    chk("mid_rst_ovf",   64'(bus.o_ovf),   0);
    bus.i_ready = 1'b1;
    put(3'b011, 9, 9, 0);
    cyc();
    put('0, 0, 0, 0);
    cyc();
    chk("mid_rst_empty", 64'(bus.o_valid), 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NCH; k++) begin
        bus.i_wen[k] = ($urandom_range(0, 9) < 6);
        bus.i_data[k*W +: W] = W'($urandom);
      end
      mode        = 2'($urandom);
      bus.i_ready = ($urandom_range(0, 9) < 7);
      clr         = ($urandom_range(0, 29) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      cyc();
    end
    put('0, 0, 0, 0);
    clr = 1'b0;
    rst = 1'b0;
    bus.i_ready = 1'b1;
    repeat (10) cyc();
    chk("sb_drained", 64'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/part_join_n.md
Name: part_join_n

Overview:
- Parametrised N-channel join-and-combine block; single clock domain.
- Each channel has its own synchronous FIFO. When every channel holds at least one word, one word is popped from all channels together.
- The popped words are combined according to a runtime-selected mode, and the result is presented on a valid/ready output port.
- Successor to the fixed three-channel a + b*c combiner. Adds width, depth and channel generalisation, output backpressure, overflow reporting and a join counter.

Parameters:
- NCH, 3, number of input channels (2..8; MAC mode requires NCH >= 3).
- W, 8, input word width per channel.
- DEPTH, 4, per-channel FIFO depth in words; power of 2, >= 2.
- OW, 8, output width; results are truncated modulo 2^OW.
- CNTW, 16, width of the join counter.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_mode  in  2  combine mode: 0 SUM, 1 MAC, 2 MAX, 3 reserved (behaves as SUM).
- i_wen  in  NCH  per-channel write enable.
- i_data  in  NCH*W  channel k occupies bits [k*W +: W].
- o_full  out  NCH  per-channel FIFO full (count == DEPTH).
- o_ovf  out  NCH  sticky per-channel overflow flag.
- i_clr_ovf  in  1  clears all o_ovf bits.
- o_valid  out  1  output word valid.
- i_ready  in  1  downstream accepts the word.
- o_data  out  OW  combined result.
- o_joins  out  CNTW  number of joins performed; wraps.

Behaviour:
- Reset (synchronous i_rst = 1):
  - All FIFOs empty (pointers and counts = 0).
  - o_full = 0, o_ovf = 0, o_valid = 0, o_data = 0, o_joins = 0.
  - Writes in the reset cycle are ignored.
  - A reset mid-operation discards all buffered words and any pending output.
- Write path:
  - If i_wen[k] = 1 and FIFO k is not full, the word is stored at that edge.
  - If i_wen[k] = 1 and FIFO k is full, the word is dropped and o_ovf[k] is set. This holds even if FIFO k is popped in the same cycle; fullness is judged on the pre-edge count.
  - o_ovf[k] clears only on i_rst or i_clr_ovf. If i_clr_ovf coincides with a new overflow, the set wins.
- Join condition: fire = (all FIFOs non-empty, pre-edge) AND (o_valid == 0 OR i_ready == 1).
- On fire:
  - Pop one word from every FIFO.
  - o_data <= combine(heads, i_mode sampled this cycle).
  - o_valid <= 1 and o_joins <= o_joins + 1 (wraps).
- Without fire:
  - If i_ready = 1, o_valid <= 0.
  - Otherwise o_valid and o_data hold; data must be stable while o_valid = 1 and i_ready = 0.
- Combine modes:
  - SUM: sum of all NCH heads, zero-extended, truncated to OW.
  - MAC: ch0 + ch1*ch2 computed at full precision, truncated to OW. Channels >= 3 are popped but ignored.
  - MAX: largest unsigned head, zero-extended or truncated to OW.
- Latency:
  - A word written at edge k is counted at edge k.
  - If the other channels are already non-empty and the output is free, fire occurs at edge k+1 and o_valid is high after edge k+1.
- Throughput: one join per cycle while all channels are non-empty and i_ready is held at 1.
- Simultaneous push and pop on the same FIFO: count is unchanged; both operations take effect.
- FIFO pointers wrap modulo DEPTH; count runs 0..DEPTH.
- Empty channel: no fire occurs; the other FIFOs keep their data.

Decomposition:
- Package part_join_pkg holds:
  - mode constants MODE_SUM = 2'd0, MODE_MAC = 2'd1, MODE_MAX = 2'd2;
  - a function computing clog2 for pointer widths.
- Sub-module part_sync_fifo(W, DEPTH) provides push, pop, head data, empty, full and count. It is instantiated NCH times through a generate loop.
- Combine logic and the output register stay in the top-level module.

Test Plan:
- Reset then MAC mode, NCH = 3: write 5, 3, 4 one per channel in the same cycle, i_ready = 1 -> o_valid pulses one cycle, one edge after the writes, with o_data = 17 and o_joins = 1.
- SUM mode, words 200, 100, 10 -> o_data = 54 (310 mod 256). MAX mode, words 7, 250, 9 -> o_data = 250.
- Backpressure: i_ready = 0 with 3 queued joins -> o_valid = 1 and o_data holds the first result, no further pops. Then i_ready = 1 for 3 cycles -> 3 consecutive results, then o_valid = 0.
- Overflow: 5 writes to channel 0 with DEPTH = 4 and no pops -> o_full[0] = 1 after the 4th write, o_ovf[0] = 1 after the 5th, FIFO still holds the first 4 words. Then i_clr_ovf -> o_ovf[0] = 0.
- Partial data: channels 0 and 1 written, channel 2 empty for 10 cycles -> no o_valid. Write channel 2 -> single join using the oldest words.
- Mid-stream reset with 2 words per FIFO and o_valid = 1 -> next cycle o_valid = 0, all FIFOs empty, o_joins = 0, o_ovf = 0.
